pipelined_subtractor: RTL

//  Two-stage pipelined WIDTH-bit unsigned/two's-complement subtractor: diff = a - b.

---
 rtl/pipelined_subtractor_if.sv | 52 +++++
 rtl/pipelined_subtractor.sv | 115 +++++++++++
 2 files changed

// File: rtl/pipelined_subtractor_if.sv
// pipelined_subtractor_if
//  Handshake and data bundle for pipelined_subtractor.
//  Upstream side:   in_valid, in_ready, a (minuend), b (subtrahend).
//  Downstream side: out_valid, out_ready, diff, borrow_out, and overflow when
//                   SUB_OVF_EN is defined.
//  Modports:
//    master - the environment: drives operands and out_ready, observes results.
//    slave  - the subtractor: accepts operands and produces results.
//  Configuration macro: SUB_OVF_EN adds the overflow signal.
interface pipelined_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SUB_OVF_EN
    logic             overflow;
`endif

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
`ifdef SUB_OVF_EN
        input  overflow,
`endif
        input  borrow_out
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
`ifdef SUB_OVF_EN
        output overflow,
`endif
        output borrow_out
    );
endinterface

// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor
//  Two-stage pipelined WIDTH-bit subtractor: diff = (a - b) mod 2^WIDTH, with
//  borrow_out = 1 when a < b (unsigned). Stage 1 subtracts the low SPLIT bits
//  and registers the borrow; stage 2 subtracts the high bits using that
//  registered borrow. Valid/ready handshake on both sides, full backpressure,
//  at most two results in flight, 2-cycle latency, 1 result/cycle throughput.
//  Ports:
//    clk    - single clock, rising edge
//    rst_n  - synchronous reset, active low
//    bus    - pipelined_subtractor_if.slave (operands in, results out)
//  Configuration macro: SUB_OVF_EN adds a registered signed-overflow output.
module pipelined_subtractor #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipelined_subtractor_if.slave  bus
);
    localparam int HI = WIDTH - SPLIT;

    // Stage 1 state
    logic             s1_valid_r;
    logic [SPLIT-1:0] lo_r;
    logic             lo_borrow_r;
    logic [HI-1:0]    a_hi_r;
    logic [HI-1:0]    b_hi_r;
`ifdef SUB_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             overflow_r;
`endif

    // Stage 2 (output) state
    logic             out_valid_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;

    // Handshake and arithmetic terms
    logic             s2_load_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [SPLIT:0]   lo_sum_s;
    logic [HI:0]      hi_sum_s;

    // Stage 2 can take stage 1 whenever the output slot is empty or draining.
    assign s2_load_s  = s1_valid_r && (!out_valid_r || bus.out_ready);
    assign in_ready_s = !s1_valid_r || s2_load_s;
    assign accept_s   = bus.in_valid && in_ready_s;

    // The extra MSB of each extended subtraction is the borrow out of that half.
    assign lo_sum_s = {1'b0, bus.a[SPLIT-1:0]} - {1'b0, bus.b[SPLIT-1:0]};
    assign hi_sum_s = {1'b0, a_hi_r} - {1'b0, b_hi_r} - {{HI{1'b0}}, lo_borrow_r};

    // Stage 1: capture low-half difference and high-half operands on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            lo_r        <= {SPLIT{1'b0}};
            lo_borrow_r <= 1'b0;
            a_hi_r      <= {HI{1'b0}};
            b_hi_r      <= {HI{1'b0}};
`ifdef SUB_OVF_EN
            a_msb_r     <= 1'b0;
            b_msb_r     <= 1'b0;
`endif
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            lo_r        <= lo_sum_s[SPLIT-1:0];
            lo_borrow_r <= lo_sum_s[SPLIT];
            a_hi_r      <= bus.a[WIDTH-1:SPLIT];
            b_hi_r      <= bus.b[WIDTH-1:SPLIT];
`ifdef SUB_OVF_EN
            a_msb_r     <= bus.a[WIDTH-1];
            b_msb_r     <= bus.b[WIDTH-1];
`endif
        end else if (s2_load_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Stage 2: finish the high half; results hold while stalled or idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            diff_r      <= {WIDTH{1'b0}};
            borrow_r    <= 1'b0;
`ifdef SUB_OVF_EN
            overflow_r  <= 1'b0;
`endif
        end else if (s2_load_s) begin
            out_valid_r <= 1'b1;
            diff_r      <= {hi_sum_s[HI-1:0], lo_r};
            borrow_r    <= hi_sum_s[HI];
`ifdef SUB_OVF_EN
            // Signed overflow: operand signs differ and result sign differs from a.
            overflow_r  <= (a_msb_r != b_msb_r) && (hi_sum_s[HI-1] != a_msb_r);
`endif
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_r;
`ifdef SUB_OVF_EN
    assign bus.overflow   = overflow_r;
`endif
endmodule
